// File: rtl/mips32_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// mips32_fetch_queue_if
//   Bundles the instruction-memory request/response channel, the decode-side
//   valid/ready channel and the redirect/halt controls of the fetch queue.
//
//   master : the fetch queue itself (drives requests and the decode head)
//   slave  : the environment (instruction memory + decode + branch unit)
//
//   imem_req_valid / imem_req_ready / imem_addr   word fetch request
//   imem_rsp_valid / imem_rdata                   in-order read return
//   if_valid / if_ready / if_ir / if_npc          head instruction to decode
//   redirect_valid / redirect_pc                  taken-branch flush
//   halt                                          stop issuing new fetches
// ----------------------------------------------------------------------------
interface mips32_fetch_queue_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_ir;
    logic [AW-1:0] if_npc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_ir,
        output if_npc,
        input  redirect_valid,
        input  redirect_pc,
        input  halt
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_ir,
        input  if_npc,
        output redirect_valid,
        output redirect_pc,
        output halt
    );
endinterface

// File: rtl/mips32_fetch_queue.sv
// ----------------------------------------------------------------------------
// mips32_fetch_queue
//   Instruction prefetch queue between a variable-latency instruction memory
//   and the IF/ID register. Issues in-order word fetches, buffers up to DEPTH
//   instructions and hands them to decode with their next-PC (PC+1, word
//   addressed). A redirect flushes the queue; responses to fetches that were
//   in flight at the time are counted in drop_cnt and discarded on return.
//
// Ports
//   clk1   clock, all state on posedge
//   rst_n  asynchronous reset, active low
//   bus    mips32_fetch_queue_if.master (imem request/response, decode head,
//          redirect, halt)
//
// Parameters
//   DEPTH  queue entries and max outstanding fetches (power of 2, >= 2)
//   AW     word-address width
//   DW     instruction width
//
// Configuration
//   FQ_BYPASS_EN  when defined, a response that fills the head entry is also
//                 presented to decode in the same cycle (and popped without
//                 being stored if decode is ready). When undefined, the decode
//                 outputs depend on registered state only.
// ----------------------------------------------------------------------------
module mips32_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input logic                  clk1,
    input logic                  rst_n,
    mips32_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PW:0]   alloc_ptr, fill_ptr, head_ptr;
    logic [PW-1:0] alloc_idx, fill_idx, head_idx;

    logic [AW-1:0] pc;
    logic [CW-1:0] drop_cnt, drop_next;
    logic          started;

    logic [CW-1:0] count, unfilled;
    logic [CW:0]   pending;
    logic          issue_ok, issue_fire;
    logic          rsp_drop, rsp_fill, rsp_used;
    logic          head_filled, bypass_hit;
    logic          if_valid_int, pop, store;

    assign alloc_idx = alloc_ptr[PW-1:0];
    assign fill_idx  = fill_ptr[PW-1:0];
    assign head_idx  = head_ptr[PW-1:0];

    assign count    = alloc_ptr - head_ptr;
    assign unfilled = alloc_ptr - fill_ptr;
    // Fetches the memory still owes us, whether they will be kept or dropped.
    assign pending  = {1'b0, unfilled} + {1'b0, drop_cnt};

    // started keeps the request line low until the first edge after reset,
    // so the reset state shows no request regardless of halt.
    assign issue_ok   = started && !bus.halt && !bus.redirect_valid
                        && (count < DEPTH_C) && (pending < DEPTH_W);
    assign issue_fire = issue_ok && bus.imem_req_ready;

    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill = bus.imem_rsp_valid && (drop_cnt == '0) && (unfilled != '0);
    assign rsp_used = rsp_drop || rsp_fill;

    assign head_filled = (count != '0) && ent_filled[head_idx];

    // Fills are in order, so an unfilled head is always the fill target.
`ifdef FQ_BYPASS_EN
    assign bypass_hit = rsp_fill && (count != '0) && !ent_filled[head_idx];
`else
    assign bypass_hit = 1'b0;
`endif

    assign if_valid_int = head_filled || bypass_hit;
    assign pop          = if_valid_int && bus.if_ready && !bus.redirect_valid;
    // A bypassed response that pops immediately never needs storing.
    assign store        = rsp_fill && !(bypass_hit && pop);

    // A same-cycle response consumes one of the owed fetches.
    assign drop_next = drop_cnt + unfilled - CW'(rsp_used);

    assign bus.imem_req_valid = issue_ok;
    assign bus.imem_addr      = pc;
    assign bus.if_valid       = if_valid_int;

    always_comb begin
        bus.if_ir  = '0;
        bus.if_npc = '0;
        if (head_filled) begin
            bus.if_ir  = ent_data[head_idx];
            bus.if_npc = ent_addr[head_idx] + AW'(1);
        end else if (bypass_hit) begin
            bus.if_ir  = bus.imem_rdata;
            bus.if_npc = ent_addr[head_idx] + AW'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            drop_cnt   <= '0;
            started    <= 1'b0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            started <= 1'b1;
            if (bus.redirect_valid) begin
                // Redirect wins over issue, fill and pop in the same cycle.
                pc         <= bus.redirect_pc;
                alloc_ptr  <= '0;
                fill_ptr   <= '0;
                head_ptr   <= '0;
                ent_filled <= '0;
                drop_cnt   <= drop_next;
            end else begin
                if (pop) begin
                    head_ptr             <= head_ptr + PTR_ONE;
                    ent_filled[head_idx] <= 1'b0;
                end
                if (issue_fire) begin
                    ent_addr[alloc_idx]   <= pc;
                    ent_filled[alloc_idx] <= 1'b0;
                    alloc_ptr             <= alloc_ptr + PTR_ONE;
                    pc                    <= pc + AW'(1);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (rsp_fill) begin
                    fill_ptr <= fill_ptr + PTR_ONE;
                    if (store) begin
                        ent_data[fill_idx]   <= bus.imem_rdata;
                        ent_filled[fill_idx] <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mips32_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_mips32_fetch_queue
//   Directed bench for mips32_fetch_queue: an in-order fixed-latency memory
//   model, a monitor recording every issued request and every popped
//   instruction, and hand-computed expectations for each scenario.
// ----------------------------------------------------------------------------
module tb_mips32_fetch_queue;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk1  = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk1 = ~clk1;

    mips32_fetch_queue_if #(.AW(AW), .DW(DW)) bus ();

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'hA000_0000 | {22'h0, a};
    endfunction

    int edge_cnt = 0;
    always @(posedge clk1) edge_cnt <= edge_cnt + 1;

    // memory model: in-order, fixed latency lat (edges from accept to sample)
    typedef struct { logic [AW-1:0] addr; int due; } req_t;
    req_t pend[$];
    int   lat = 1;

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata     = '0;
        forever begin
            @(negedge clk1);
            if (!rst_n) begin
                pend.delete();
            end else begin
                if (bus.imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
                if (bus.imem_req_valid && bus.imem_req_ready)
                    pend.push_back('{bus.imem_addr, edge_cnt + 1 + lat});
            end
            @(posedge clk1);
            #1;
            if (rst_n && pend.size() > 0 && pend[0].due <= edge_cnt + 1) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rdata     = mem_word(pend[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rdata     = '0;
            end
        end
    end

    // monitor: handshakes completing at the next edge
    typedef struct { logic [DW-1:0] ir; logic [AW-1:0] npc; int e; } pop_t;
    typedef struct { logic [AW-1:0] addr; int e; } iss_t;
    pop_t pops[$];
    iss_t iss[$];

    always @(negedge clk1) begin
        if (rst_n) begin
            if (bus.if_valid && bus.if_ready && !bus.redirect_valid)
                pops.push_back('{bus.if_ir, bus.if_npc, edge_cnt + 1});
            if (bus.imem_req_valid && bus.imem_req_ready)
                iss.push_back('{bus.imem_addr, edge_cnt + 1});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic do_reset(input int l, input logic rdy);
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = rdy;
        bus.imem_req_ready = 1'b1;
        lat                = l;
        rst_n              = 1'b0;
        cyc(2);
        pops.delete();
        iss.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_iss(input int n, input string tag);
        int k = 0;
        while (iss.size() < n && k < 60) begin
            cyc(1);
            k++;
        end
        check_eq(tag, iss.size() >= n, 1);
    endtask

    task automatic wait_pops(input int n, input string tag);
        int k = 0;
        while (pops.size() < n && k < 80) begin
            cyc(1);
            k++;
        end
        check_eq(tag, pops.size() >= n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        cyc(2);
        @(negedge clk1);
        check_eq("rst_req_valid", bus.imem_req_valid, 0);
        check_eq("rst_if_valid",  bus.if_valid, 0);
        check_eq("rst_imem_addr", bus.imem_addr, 0);
        check_eq("rst_if_ir",     bus.if_ir, 0);
        check_eq("rst_if_npc",    bus.if_npc, 0);

        // 1: streaming at latency 1
        do_reset(1, 1'b1);
        wait_pops(4, "t1_pops_timeout");
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_ir%0d", i),   pops[i].ir,  32'hA000_0000 + i);
            check_eq($sformatf("t1_npc%0d", i),  pops[i].npc, i + 1);
            check_eq($sformatf("t1_addr%0d", i), iss[i].addr, i);
        end
        check_eq("t1_latency", pops[0].e - iss[0].e, 2);

        // 2: decode stalled -> queue fills, then one pop frees one slot
        do_reset(1, 1'b0);
        cyc(10);
        check_eq("t2_issued", iss.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t2_addr%0d", i), iss[i].addr, i);
        @(negedge clk1);
        check_eq("t2_req_low",  bus.imem_req_valid, 0);
        check_eq("t2_if_valid", bus.if_valid, 1);
        check_eq("t2_head_ir",  bus.if_ir, 32'hA000_0000);
        cyc(1);
        bus.if_ready = 1'b1;
        cyc(1);
        bus.if_ready = 1'b0;
        cyc(5);
        check_eq("t2_pops",      pops.size(), 1);
        check_eq("t2_pop_ir",    pops[0].ir, 32'hA000_0000);
        check_eq("t2_issued2",   iss.size(), 5);
        check_eq("t2_addr4",     iss[4].addr, 4);
        check_eq("t2_issue_lag", iss[4].e - pops[0].e, 1);

        // 3: redirect with 3 outstanding at latency 5
        do_reset(5, 1'b1);
        wait_iss(3, "t3_iss_timeout");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h020;
        cyc(1);
        bus.redirect_valid = 1'b0;
        wait_pops(2, "t3_pops_timeout");
        check_eq("t3_ir0",   pops[0].ir,  32'hA000_0020);
        check_eq("t3_npc0",  pops[0].npc, 10'h021);
        check_eq("t3_ir1",   pops[1].ir,  32'hA000_0021);
        check_eq("t3_addr3", iss[3].addr, 10'h020);

        // 4: redirect in the same cycle as a response, 2 unfilled -> 1 dropped
        do_reset(2, 1'b1);
        wait_iss(3, "t4_iss_timeout");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h040;
        cyc(1);
        bus.redirect_valid = 1'b0;
        wait_pops(2, "t4_pops_timeout");
        check_eq("t4_ir0",  pops[0].ir,  32'hA000_0040);
        check_eq("t4_npc0", pops[0].npc, 10'h041);
        check_eq("t4_ir1",  pops[1].ir,  32'hA000_0041);

        // 5: halt with 2 queued and 1 outstanding
        do_reset(1, 1'b0);
        wait_iss(3, "t5_iss_timeout");
        bus.halt     = 1'b1;
        bus.if_ready = 1'b1;
        cyc(12);
        check_eq("t5_no_issue", iss.size(), 3);
        check_eq("t5_drained",  pops.size(), 3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("t5_ir%0d", i), pops[i].ir, 32'hA000_0000 + i);
        @(negedge clk1);
        check_eq("t5_req_low", bus.imem_req_valid, 0);
        cyc(1);
        bus.halt = 1'b0;
        wait_iss(4, "t5_resume_timeout");
        check_eq("t5_resume_addr", iss[3].addr, 3);

        // 6: pc wraps from 0x3FF to 0x000
        do_reset(1, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h3FF;
        cyc(1);
        bus.redirect_valid = 1'b0;
        wait_pops(2, "t6_pops_timeout");
        check_eq("t6_addr0", iss[0].addr, 10'h3FF);
        check_eq("t6_addr1", iss[1].addr, 10'h000);
        check_eq("t6_ir0",   pops[0].ir,  32'hA000_03FF);
        check_eq("t6_npc0",  pops[0].npc, 10'h000);
        check_eq("t6_ir1",   pops[1].ir,  32'hA000_0000);
        check_eq("t6_npc1",  pops[1].npc, 10'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
